// File: rtl/mmio_bus_bridge.sv
// Address decoder between the CPU memory port and either RAM or the peripheral
// window (timer, LED, 7-segment, cycle counter). Read data is returned combinationally.
module mmio_bus_bridge #(
  parameter int          RAM_WORDS   = 256,
  parameter logic [31:0] PERIPH_BASE = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Read_data,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_we,
  output logic        ram_re,
  input  logic [31:0] ram_rdata,
  output logic [7:0]  leds,
  output logic [11:0] digi,
  output logic        irq,
  output logic [31:0] sys_tick
);

  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
  localparam logic [5:0] OFF_TH   = 6'd0;
  localparam logic [5:0] OFF_TL   = 6'd1;
  localparam logic [5:0] OFF_TCON = 6'd2;
  localparam logic [5:0] OFF_LED  = 6'd3;
  localparam logic [5:0] OFF_DIGI = 6'd4;
  localparam logic [5:0] OFF_TICK = 6'd5;

  logic        ram_hit, periph_hit, wr_periph;
  logic [5:0]  off;
  logic [31:0] th, tl, tick;
  logic [2:0]  tcon;
  logic [7:0]  led_q;
  logic [11:0] digi_q;
  logic        ovf, set_st;

  // RAM_BYTES is word-aligned, so the full compare equals a compare on Address[31:2]
  assign ram_hit    = Address < RAM_BYTES;
  assign periph_hit = Address[31:8] == PERIPH_BASE[31:8];
  assign off        = Address[7:2];
  assign wr_periph  = MemWrite & periph_hit;

  assign ram_addr  = {2'b00, Address[31:2]};
  assign ram_wdata = Write_data;
  assign ram_we    = MemWrite & ram_hit;
  assign ram_re    = MemRead & ram_hit;

  assign ovf    = tcon[0] & (tl == 32'hFFFF_FFFF);
  assign set_st = ovf & tcon[1];

  assign leds     = led_q;
  assign digi     = digi_q;
  assign irq      = tcon[1] & tcon[2];
  assign sys_tick = tick;

  always_comb begin
    Read_data = 32'h0;
    if (ram_hit) begin
      Read_data = ram_rdata;
    end else if (periph_hit) begin
      case (off)
        OFF_TH:   Read_data = th;
        OFF_TL:   Read_data = tl;
        OFF_TCON: Read_data = {29'h0, tcon};
        OFF_LED:  Read_data = {24'h0, led_q};
        OFF_DIGI: Read_data = {20'h0, digi_q};
        OFF_TICK: Read_data = tick;
        default:  Read_data = 32'h0;
      endcase
    end
  end

  // CPU writes are placed after the timer update so they take priority;
  // a TCON write still ORs in a same-cycle overflow so no interrupt is lost.
  always_ff @(posedge clk) begin
    if (!reset) begin
      th     <= 32'h0;
      tl     <= 32'h0;
      tcon   <= 3'b000;
      led_q  <= 8'h0;
      digi_q <= 12'h0;
      tick   <= 32'h0;
    end else begin
      tick <= tick + 32'd1;
      if (tcon[0]) tl <= ovf ? th : tl + 32'd1;
      if (set_st) tcon[2] <= 1'b1;
      if (wr_periph) begin
        case (off)
          OFF_TH:   th     <= Write_data;
          OFF_TL:   tl     <= Write_data;
          OFF_TCON: tcon   <= {Write_data[2] | set_st, Write_data[1:0]};
          OFF_LED:  led_q  <= Write_data[7:0];
          OFF_DIGI: digi_q <= Write_data[11:0];
          default:  ;
        endcase
      end
    end
  end

endmodule
